// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one WIDTH-bit add/sub/and/xor/slt, LSB first, one bit per clock.
// Operands live in shift registers; a single carry flop links successive bits.
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, busy_q, done_q, zero_q, carry_q, err_q;

  logic             ai, bi, s, c_d, arith;
  logic [WIDTH-1:0] shifted, res_fin;

  function automatic logic is_legal(input logic [2:0] o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_AND) ||
           (o == OP_XOR) || (o == OP_SLT);
  endfunction

  // Single 1-bit slice; sub/slt run as A + ~B + 1 with carry preset to 1.
  always_comb begin
    ai      = a_q[0];
    bi      = b_q[0] ^ ((op_q == OP_SUB) || (op_q == OP_SLT));
    arith   = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
    s       = 1'b0;
    c_d     = c_q;
    case (op_q)
      OP_ADD, OP_SUB, OP_SLT: begin
        s   = ai ^ bi ^ c_q;
        c_d = (ai & bi) | (ai & c_q) | (bi & c_q);
      end
      OP_AND:  s = ai & b_q[0];
      OP_XOR:  s = ai ^ b_q[0];
      default: s = 1'b0;
    endcase
    shifted = {s, result_q[WIDTH-1:1]};
    res_fin = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, ~c_d} : shifted;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            cnt_q <= '0;
            c_q   <= (op == OP_SUB) || (op == OP_SLT);
            if (is_legal(op)) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= '0;
              zero_q   <= 1'b1;
              carry_q  <= 1'b0;
              err_q    <= 1'b1;
            end
          end
        end
        RUN: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          c_q      <= c_d;
          cnt_q    <= cnt_q + 1'b1;
          result_q <= shifted;
          if (cnt_q == LAST) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= res_fin;
            zero_q   <= (res_fin == '0);
            carry_q  <= arith ? c_d : 1'b0;
            err_q    <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry_out = carry_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq (WIDTH=8): arithmetic, logic, illegal op,
// held-start back-to-back, and asynchronous reset in the middle of an op.
module tb_alu_serial_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic       busy, done, zero, carry_out, err;
  logic [7:0] result;

  int pass_cnt = 0;
  int total_cnt = 0;

  alu_serial_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .carry_out(carry_out), .err(err)
  );

  always #5 clk = ~clk;

  // Issue one op and watch until done (bounded); cycle 1 is the cycle after the start edge.
  task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int done_cyc, output int busy_cyc);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = -1;
    busy_cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if ({busy, done, result, zero, carry_out, err} !== 13'd0) $display("FAIL reset_outputs got=%h exp=0", {busy, done, result, zero, carry_out, err}); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL reset_idle busy/done got=%b exp=00", {busy, done}); else pass_cnt++;
  endtask

  task automatic test_add;
    int dc, bc;
    run_op(3'b000, 8'h7F, 8'h01, dc, bc);
    total_cnt++; if (dc !== 9) $display("FAIL add_latency got=%0d exp=9", dc); else pass_cnt++;
    total_cnt++; if (bc !== 8) $display("FAIL add_busy_cycles got=%0d exp=8", bc); else pass_cnt++;
    total_cnt++; if ({result, zero, carry_out, err} !== {8'h80, 3'b000}) $display("FAIL add_7f_01 got=%h/%b%b%b exp=80/000", result, zero, carry_out, err); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({done, result} !== {1'b0, 8'h80}) $display("FAIL done_pulse_hold got=%b/%h exp=0/80", done, result); else pass_cnt++;
    run_op(3'b000, 8'hFF, 8'h01, dc, bc);
    total_cnt++; if ({result, zero, carry_out} !== {8'h00, 2'b11}) $display("FAIL add_ff_01 got=%h/%b%b exp=00/11", result, zero, carry_out); else pass_cnt++;
  endtask

  task automatic test_sub_slt;
    int dc, bc;
    run_op(3'b001, 8'h07, 8'h07, dc, bc);
    total_cnt++; if ({result, zero, carry_out} !== {8'h00, 2'b11}) $display("FAIL sub_07_07 got=%h/%b%b exp=00/11", result, zero, carry_out); else pass_cnt++;
    run_op(3'b001, 8'h05, 8'h07, dc, bc);
    total_cnt++; if ({result, zero, carry_out} !== {8'hFE, 2'b00}) $display("FAIL sub_05_07 got=%h/%b%b exp=fe/00", result, zero, carry_out); else pass_cnt++;
    run_op(3'b101, 8'h05, 8'h07, dc, bc);
    total_cnt++; if ({result, zero, carry_out} !== {8'h01, 2'b00}) $display("FAIL slt_05_07 got=%h/%b%b exp=01/00", result, zero, carry_out); else pass_cnt++;
    total_cnt++; if (dc !== 9) $display("FAIL slt_latency got=%0d exp=9", dc); else pass_cnt++;
    run_op(3'b101, 8'h07, 8'h05, dc, bc);
    total_cnt++; if ({result, zero, carry_out} !== {8'h00, 2'b11}) $display("FAIL slt_07_05 got=%h/%b%b exp=00/11", result, zero, carry_out); else pass_cnt++;
  endtask

  task automatic test_illegal;
    int dc, bc;
    run_op(3'b110, 8'h12, 8'h34, dc, bc);
    total_cnt++; if (dc !== 1) $display("FAIL illegal_latency got=%0d exp=1", dc); else pass_cnt++;
    total_cnt++; if (bc !== 0) $display("FAIL illegal_busy got=%0d exp=0", bc); else pass_cnt++;
    total_cnt++; if ({result, zero, carry_out, err} !== {8'h00, 3'b101}) $display("FAIL illegal_flags got=%h/%b%b%b exp=00/101", result, zero, carry_out, err); else pass_cnt++;
  endtask

  task automatic test_logic;
    int dc, bc;
    run_op(3'b010, 8'hF0, 8'h3C, dc, bc);
    total_cnt++; if ({result, zero, carry_out, err} !== {8'h30, 3'b000}) $display("FAIL and_f0_3c got=%h/%b%b%b exp=30/000", result, zero, carry_out, err); else pass_cnt++;
    run_op(3'b011, 8'hAA, 8'hFF, dc, bc);
    total_cnt++; if ({result, zero, carry_out, err} !== {8'h55, 3'b000}) $display("FAIL xor_aa_ff got=%h/%b%b%b exp=55/000", result, zero, carry_out, err); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int ndone, d1, d2, bcnt;
    logic [7:0] r1, r2;
    ndone = 0; d1 = -1; d2 = -1; bcnt = 0; r1 = 8'h00; r2 = 8'h00;
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 8'h10; b = 8'h01;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) a = 8'h20;
      if (busy) bcnt++;
      if (done) begin
        ndone++;
        if (ndone == 1) begin d1 = i; r1 = result; end
        else if (ndone == 2) begin d2 = i; r2 = result; end
      end
    end
    start = 1'b0;
    total_cnt++; if (ndone !== 2) $display("FAIL b2b_done_count got=%0d exp=2", ndone); else pass_cnt++;
    total_cnt++; if ({d1, d2} !== {32'd9, 32'd19}) $display("FAIL b2b_done_cycles got=%0d,%0d exp=9,19", d1, d2); else pass_cnt++;
    total_cnt++; if (bcnt !== 16) $display("FAIL b2b_busy_cycles got=%0d exp=16", bcnt); else pass_cnt++;
    total_cnt++; if ({r1, r2} !== {8'h11, 8'h21}) $display("FAIL b2b_results got=%h,%h exp=11,21", r1, r2); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    int dc, bc, seen;
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 8'hFF; b = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++; if (busy !== 1'b1) $display("FAIL midrun_busy got=%b exp=1", busy); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({busy, done, result, zero, carry_out, err} !== 13'd0) $display("FAIL async_reset got=%h exp=0", {busy, done, result, zero, carry_out, err}); else pass_cnt++;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done || busy) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL aborted_no_done got=%0d exp=0", seen); else pass_cnt++;
    run_op(3'b000, 8'h12, 8'h34, dc, bc);
    total_cnt++; if ({dc, result, zero, carry_out, err} !== {32'd9, 8'h46, 3'b000}) $display("FAIL post_reset_add got=%0d/%h/%b%b%b exp=9/46/000", dc, result, zero, carry_out, err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_illegal();
    test_logic();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
